periph_axi_bridge: RTL
======================

PERIPH_AXI_BRIDGE -- requirements
Module: periph_axi_bridge

Interface
REQ-001 Parameter AW_W, default 44, SHALL set the packed AW message width.
REQ-002 Parameter W_W, default 73, SHALL set the packed W message width.
REQ-003 Parameter B_W, default 6, SHALL set the packed B message width.
REQ-004 Parameter AR_W, default 44, SHALL set the packed AR message width.
REQ-005 Parameter R_W, default 71, SHALL set the packed R message width.
REQ-006 Parameter R_LAST_BIT, default 0, SHALL give the bit index of the "last" flag within the R message.
REQ-007 Parameter DEPTH, default 2, SHALL set the per-channel buffer depth; it is a power of two, at least 2.
REQ-008 Parameter MAX_OUTST, default 4, SHALL set the maximum number of outstanding writes and the maximum number of outstanding reads; it is at least 1.
REQ-009 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-010 Port reset_bar, input, 1: asynchronous, active-low reset.
REQ-011 Ports s_aw_valid in 1, s_aw_ready out 1, s_aw_msg in AW_W: the upstream (core-side) write-address channel.
REQ-012 Ports s_w_valid in 1, s_w_ready out 1, s_w_msg in W_W: the upstream write-data channel.
REQ-013 Ports s_b_valid out 1, s_b_ready in 1, s_b_msg out B_W: the upstream write-response channel.
REQ-014 Ports s_ar_valid in 1, s_ar_ready out 1, s_ar_msg in AR_W: the upstream read-address channel.
REQ-015 Ports s_r_valid out 1, s_r_ready in 1, s_r_msg out R_W: the upstream read-data channel.
REQ-016 Ports m_aw_*, m_w_*, m_b_*, m_ar_*, m_r_*: the downstream (subsystem-side) mirrors of REQ-011 to REQ-015, with the same widths and opposite directions.
REQ-017 Ports wr_outst and rd_outst, out, $clog2(MAX_OUTST+1): the current outstanding-transaction counts.
REQ-018 Port idle, out, 1: high when all five buffers are empty and both counts are zero.

Function
REQ-019 Each of the five channels SHALL pass through an independent FIFO of DEPTH entries, in the channel's direction.
REQ-020 A transfer SHALL occur on a rising edge where valid and ready are both high; the message is captured unmodified.
REQ-021 A FIFO's input ready SHALL equal "not full", with no combinational path from its output ready.
REQ-022 A FIFO's output valid SHALL equal "not empty", and its output msg SHALL be the head entry, driven from a register.
REQ-023 Minimum latency SHALL be 1 cycle: a message accepted at edge N is visible at the output after edge N.
REQ-024 Simultaneous push and pop SHALL keep the occupancy unchanged and preserve order; pointers SHALL wrap modulo DEPTH.
REQ-025 Once valid is asserted on an output, msg SHALL stay stable until the transfer occurs.
REQ-026 wr_outst SHALL increment on each s_aw transfer and decrement on each s_b transfer; when both occur in the same cycle it SHALL be unchanged.
REQ-027 rd_outst SHALL increment on each s_ar transfer and decrement on each s_r transfer whose msg[R_LAST_BIT] is 1; simultaneous events SHALL leave it unchanged.
REQ-028 s_aw_ready SHALL be forced low while wr_outst equals MAX_OUTST.
REQ-029 s_ar_ready SHALL be forced low while rd_outst equals MAX_OUTST.
REQ-030 The W channel SHALL NOT be gated by wr_outst.
REQ-031 A decrement at count zero (protocol violation) SHALL saturate at zero, and a simulation assertion SHALL flag it.

Reset
REQ-032 While reset_bar is low, all FIFOs SHALL be empty, every valid output low, every ready output low, both counts 0, and idle low.
REQ-033 Readies SHALL rise on the first rising edge after reset_bar deasserts, and idle SHALL then go high.
REQ-034 Reset asserted mid-transaction SHALL discard all buffered messages immediately and asynchronously.

Structure
REQ-035 Default widths, the DEPTH default, and an outstanding-count width function SHALL live in package periph_axi_pkg.
REQ-036 One parametrised sub-module, axi_chan_fifo (WIDTH, DEPTH), SHALL be instantiated five times.

Verification
REQ-037 Single write: AW=44'h1234 and W=73'h1 at cycle 0 -> both appear on m_* at cycle 1; return m_b=6'h0 -> s_b_valid next cycle; wr_outst goes 0->1->0.
REQ-038 Backpressure: hold m_ar_ready=0 and push 3 ARs with DEPTH=2 -> s_ar_ready low after 2 transfers; release -> order preserved and no message lost.
REQ-039 Limit: MAX_OUTST=4 with 5 back-to-back ARs and no R -> s_ar_ready low at rd_outst=4; one R with last=1 -> readiness restored one cycle later.
REQ-040 Burst: one AR, then 4 R beats with last only on beat 4 -> rd_outst stays 1 through beat 3 and reaches 0 after beat 4.
REQ-041 Simultaneous events: AW transfer and B transfer in the same cycle at wr_outst=2 -> wr_outst stays 2.
REQ-042 Reset: assert reset_bar low with 2 entries buffered -> all valids, readies and counts are 0 immediately; after release, idle=1.

Source files
------------

// File: rtl/periph_axi_pkg.sv
// Shared defaults for the peripheral AXI bridge: message widths, buffer depth,
// outstanding limit, and the width of the outstanding-transaction counters.
package periph_axi_pkg;

    localparam int AW_W_DEF       = 44;
    localparam int W_W_DEF        = 73;
    localparam int B_W_DEF        = 6;
    localparam int AR_W_DEF       = 44;
    localparam int R_W_DEF        = 71;
    localparam int R_LAST_BIT_DEF = 0;
    localparam int DEPTH_DEF      = 2;
    localparam int MAX_OUTST_DEF  = 4;

    // Bits needed to hold every count from 0 up to and including max_outst.
    function automatic int outst_w(input int max_outst);
        return $clog2(max_outst + 1);
    endfunction

endpackage

// File: rtl/axi_chan_fifo.sv
// Single-clock valid/ready FIFO for one bridge channel. Input ready depends
// only on occupancy and the enable, never on out_ready; the output message
// is the registered head entry and stays stable until it is popped.
module axi_chan_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_bar,
    input  logic             in_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_msg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_msg
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push;
    logic             pop;

    assign in_ready  = in_en && (cnt_q != CNT_W'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign out_msg   = mem_q[rd_ptr_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Next storage contents: write the incoming message at the tail.
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = in_msg;
    end

    // Pointer and occupancy state; reset empties the FIFO asynchronously.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Message storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the zero occupancy hides stale entries.
        mem_q <= mem_d;
    end

endmodule

// File: rtl/periph_axi_bridge.sv
// Core-to-subsystem AXI bridge: five independent channel FIFOs plus
// outstanding-write and outstanding-read counters that throttle AW and AR.
module periph_axi_bridge
    import periph_axi_pkg::*;
#(
    parameter int AW_W       = AW_W_DEF,
    parameter int W_W        = W_W_DEF,
    parameter int B_W        = B_W_DEF,
    parameter int AR_W       = AR_W_DEF,
    parameter int R_W        = R_W_DEF,
    parameter int R_LAST_BIT = R_LAST_BIT_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int MAX_OUTST  = MAX_OUTST_DEF,
    localparam int OW        = outst_w(MAX_OUTST)
) (
    input  logic            clk,
    input  logic            reset_bar,
    // upstream (core side)
    input  logic            s_aw_valid,
    output logic            s_aw_ready,
    input  logic [AW_W-1:0] s_aw_msg,
    input  logic            s_w_valid,
    output logic            s_w_ready,
    input  logic [W_W-1:0]  s_w_msg,
    output logic            s_b_valid,
    input  logic            s_b_ready,
    output logic [B_W-1:0]  s_b_msg,
    input  logic            s_ar_valid,
    output logic            s_ar_ready,
    input  logic [AR_W-1:0] s_ar_msg,
    output logic            s_r_valid,
    input  logic            s_r_ready,
    output logic [R_W-1:0]  s_r_msg,
    // downstream (subsystem side)
    output logic            m_aw_valid,
    input  logic            m_aw_ready,
    output logic [AW_W-1:0] m_aw_msg,
    output logic            m_w_valid,
    input  logic            m_w_ready,
    output logic [W_W-1:0]  m_w_msg,
    input  logic            m_b_valid,
    output logic            m_b_ready,
    input  logic [B_W-1:0]  m_b_msg,
    output logic            m_ar_valid,
    input  logic            m_ar_ready,
    output logic [AR_W-1:0] m_ar_msg,
    input  logic            m_r_valid,
    output logic            m_r_ready,
    input  logic [R_W-1:0]  m_r_msg,
    // status
    output logic [OW-1:0]   wr_outst,
    output logic [OW-1:0]   rd_outst,
    output logic            idle
);

    logic          run_q, run_d;
    logic [OW-1:0] wr_outst_q, wr_outst_d;
    logic [OW-1:0] rd_outst_q, rd_outst_d;
    logic          wr_at_max, rd_at_max;
    logic          aw_fire, b_fire, ar_fire, r_last_fire;

    assign wr_at_max   = (wr_outst_q == OW'(MAX_OUTST));
    assign rd_at_max   = (rd_outst_q == OW'(MAX_OUTST));
    assign aw_fire     = s_aw_valid && s_aw_ready;
    assign b_fire      = s_b_valid && s_b_ready;
    assign ar_fire     = s_ar_valid && s_ar_ready;
    assign r_last_fire = s_r_valid && s_r_ready && s_r_msg[R_LAST_BIT];

    assign wr_outst = wr_outst_q;
    assign rd_outst = rd_outst_q;
    assign idle     = run_q && !m_aw_valid && !m_w_valid && !s_b_valid
                      && !m_ar_valid && !s_r_valid
                      && (wr_outst_q == '0) && (rd_outst_q == '0);

    // Outstanding counters: +1 per address transfer, -1 per completion, saturating at zero.
    always_comb begin
        run_d      = 1'b1;
        wr_outst_d = wr_outst_q;
        rd_outst_d = rd_outst_q;
        if (aw_fire && !b_fire)
            wr_outst_d = wr_outst_q + OW'(1);
        else if (b_fire && !aw_fire && (wr_outst_q != '0))
            wr_outst_d = wr_outst_q - OW'(1);
        if (ar_fire && !r_last_fire)
            rd_outst_d = rd_outst_q + OW'(1);
        else if (r_last_fire && !ar_fire && (rd_outst_q != '0))
            rd_outst_d = rd_outst_q - OW'(1);
    end

    // Run flag holds all readies low in reset and releases them on the first edge after it.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            run_q      <= 1'b0;
            wr_outst_q <= '0;
            rd_outst_q <= '0;
        end else begin
            run_q      <= run_d;
            wr_outst_q <= wr_outst_d;
            rd_outst_q <= rd_outst_d;
        end
    end

    // A completion arriving with nothing outstanding is a protocol violation.
    wr_underflow_a: assert property (@(posedge clk) disable iff (!reset_bar)
        !(b_fire && !aw_fire && (wr_outst_q == '0)));
    rd_underflow_a: assert property (@(posedge clk) disable iff (!reset_bar)
        !(r_last_fire && !ar_fire && (rd_outst_q == '0)));

    axi_chan_fifo #(.WIDTH(AW_W), .DEPTH(DEPTH)) u_aw_fifo (
        .clk(clk), .reset_bar(reset_bar), .in_en(run_q && !wr_at_max),
        .in_valid(s_aw_valid), .in_ready(s_aw_ready), .in_msg(s_aw_msg),
        .out_valid(m_aw_valid), .out_ready(m_aw_ready), .out_msg(m_aw_msg)
    );

    axi_chan_fifo #(.WIDTH(W_W), .DEPTH(DEPTH)) u_w_fifo (
        .clk(clk), .reset_bar(reset_bar), .in_en(run_q),
        .in_valid(s_w_valid), .in_ready(s_w_ready), .in_msg(s_w_msg),
        .out_valid(m_w_valid), .out_ready(m_w_ready), .out_msg(m_w_msg)
    );

    axi_chan_fifo #(.WIDTH(B_W), .DEPTH(DEPTH)) u_b_fifo (
        .clk(clk), .reset_bar(reset_bar), .in_en(run_q),
        .in_valid(m_b_valid), .in_ready(m_b_ready), .in_msg(m_b_msg),
        .out_valid(s_b_valid), .out_ready(s_b_ready), .out_msg(s_b_msg)
    );

    axi_chan_fifo #(.WIDTH(AR_W), .DEPTH(DEPTH)) u_ar_fifo (
        .clk(clk), .reset_bar(reset_bar), .in_en(run_q && !rd_at_max),
        .in_valid(s_ar_valid), .in_ready(s_ar_ready), .in_msg(s_ar_msg),
        .out_valid(m_ar_valid), .out_ready(m_ar_ready), .out_msg(m_ar_msg)
    );

    axi_chan_fifo #(.WIDTH(R_W), .DEPTH(DEPTH)) u_r_fifo (
        .clk(clk), .reset_bar(reset_bar), .in_en(run_q),
        .in_valid(m_r_valid), .in_ready(m_r_ready), .in_msg(m_r_msg),
        .out_valid(s_r_valid), .out_ready(s_r_ready), .out_msg(s_r_msg)
    );

endmodule
